// File: rtl/ostar_accum_stage.sv
// ostar_accum_stage: joins rescaled O* and scaled [V,1] streams, accumulating a saturated Q9.17 row over KV_LEN steps.
`ifndef MAX_EMBEDDING_DIM
`define MAX_EMBEDDING_DIM 64
`endif
`ifndef MAX_SEQ_LENGTH
`define MAX_SEQ_LENGTH 128
`endif
module ostar_accum_stage #(
    parameter int NUM_ELEMS = `MAX_EMBEDDING_DIM + 1,
    parameter int KV_LEN    = `MAX_SEQ_LENGTH
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic                              ostar_vld_in,
    output logic                              ostar_rdy_out,
    input  logic [NUM_ELEMS-1:0][25:0]        ostar_in,
    input  logic                              v_vld_in,
    output logic                              v_rdy_out,
    input  logic [NUM_ELEMS-1:0][25:0]        v_in,
    output logic [NUM_ELEMS-1:0][25:0]        ostar_fb,
    output logic                              o_vld_out,
    input  logic                              o_rdy_in,
    output logic [NUM_ELEMS-1:0][25:0]        o_out,
    output logic [$clog2(KV_LEN)-1:0]         kv_count,
    output logic                              busy
);
    localparam int CW = $clog2(KV_LEN);
    localparam logic [CW-1:0] KV_LAST = CW'(KV_LEN - 1);
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_e;
    state_e                       state_q;
    logic [NUM_ELEMS-1:0][25:0]   acc_q, acc_d;
    logic [CW-1:0]                kv_q;
    logic                         join_w;
    assign join_w        = (state_q == ACCUM) && ostar_vld_in && v_vld_in;
    assign ostar_rdy_out = (state_q == ACCUM) && v_vld_in;
    assign v_rdy_out     = (state_q == ACCUM) && ostar_vld_in;
    assign ostar_fb      = acc_q;
    assign o_out         = acc_q;
    assign o_vld_out     = state_q == DONE;
    assign busy          = state_q != IDLE;
    assign kv_count      = kv_q;
    // Sum at 27 bits; differing top two bits means overflow, clamp toward the sign.
    for (genvar i = 0; i < NUM_ELEMS; i++) begin : g_sat
        logic signed [26:0] s;
        assign s        = {ostar_in[i][25], ostar_in[i]} + {v_in[i][25], v_in[i]};
        assign acc_d[i] = (s[26] == s[25]) ? s[25:0] : {s[26], {25{~s[26]}}};
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            kv_q    <= '0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    acc_q   <= '0;
                    kv_q    <= '0;
                    state_q <= ACCUM;
                end
                ACCUM: if (join_w) begin
                    acc_q   <= acc_d;
                    kv_q    <= (kv_q == KV_LAST) ? kv_q : kv_q + 1'b1;
                    state_q <= (kv_q == KV_LAST) ? DONE : ACCUM;
                end
                DONE: if (o_rdy_in) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ostar_accum_stage.sv
// tb_ostar_accum_stage: directed checks of join, saturation, backpressure and async reset with KV_LEN=4, NUM_ELEMS=3.
module tb_ostar_accum_stage;
    typedef logic [2:0][25:0] vec_t;
    logic       clk = 0, rst = 0, start = 0, ostar_vld_in = 0, v_vld_in = 0, o_rdy_in = 0;
    logic       ostar_rdy_out, v_rdy_out, o_vld_out, busy;
    vec_t       ostar_in = '0, v_in = '0, ostar_fb, o_out;
    logic [1:0] kv_count;
    int         errors = 0, checks = 0;
    vec_t       held;
    ostar_accum_stage #(.NUM_ELEMS(3), .KV_LEN(4)) dut (
        .clk(clk), .rst(rst), .start(start),
        .ostar_vld_in(ostar_vld_in), .ostar_rdy_out(ostar_rdy_out), .ostar_in(ostar_in),
        .v_vld_in(v_vld_in), .v_rdy_out(v_rdy_out), .v_in(v_in),
        .ostar_fb(ostar_fb), .o_vld_out(o_vld_out), .o_rdy_in(o_rdy_in), .o_out(o_out),
        .kv_count(kv_count), .busy(busy)
    );
    always #5 clk = ~clk;
    function automatic logic [25:0] q(input int x);
        return 26'(x * 131072);
    endfunction
    function automatic vec_t vec3(input logic [25:0] a, input logic [25:0] b, input logic [25:0] c);
        vec_t v;
        v[0] = a;
        v[1] = b;
        v[2] = c;
        return v;
    endfunction
    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic join_v(input vec_t os, input vec_t v);
        ostar_in     = os;
        v_in         = v;
        ostar_vld_in = 1;
        v_vld_in     = 1;
        #1 chk("join_rdy", {ostar_rdy_out, v_rdy_out}, 2'b11);
        tick();
        ostar_vld_in = 0;
        v_vld_in     = 0;
    endtask
    task automatic pulse_start();
        start = 1;
        tick();
        start = 0;
    endtask
    initial begin
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_ovld", o_vld_out, 0);
        chk("rst_fb", ostar_fb, 0);
        chk("rst_kv", kv_count, 0);
        tick();
        rst = 1;
        tick();
        tick();
        chk("idle_wait", busy, 0);
        pulse_start();
        chk("start_busy", busy, 1);
        chk("start_kv", kv_count, 0);
        for (int k = 1; k <= 4; k++) begin
            join_v(ostar_fb, vec3(q(1), q(2), q(1)));
            chk("row_fb", ostar_fb, vec3(q(k), q(2 * k), q(k)));
            chk("row_kv", kv_count, (k == 4) ? 3 : k);
            chk("row_ovld", o_vld_out, k == 4);
        end
        chk("row_oout", o_out, vec3(q(4), q(8), q(4)));
        held = o_out;
        for (int k = 0; k < 3; k++) begin
            start = (k == 1);
            tick();
            start = 0;
            chk("bp_ovld", o_vld_out, 1);
            chk("bp_oout", o_out, held);
            chk("bp_kv", kv_count, 3);
        end
        o_rdy_in = 1;
        start    = 1;
        tick();
        o_rdy_in = 0;
        start    = 0;
        chk("done_idle", busy, 0);
        chk("done_ovld", o_vld_out, 0);
        chk("idle_fb_hold", ostar_fb, held);
        tick();
        chk("start_ignored", busy, 0);
        pulse_start();
        chk("clear_fb", ostar_fb, 0);
        ostar_in = vec3(q(7), q(7), q(7));
        v_in     = vec3(q(1), q(2), q(1));
        v_vld_in = 1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("stall_vrdy", v_rdy_out, 0);
            chk("stall_fb", ostar_fb, 0);
        end
        ostar_in     = ostar_fb;
        ostar_vld_in = 1;
        #1 chk("stall_go", v_rdy_out, 1);
        tick();
        ostar_vld_in = 0;
        v_vld_in     = 0;
        chk("stall_one_fb", ostar_fb, vec3(q(1), q(2), q(1)));
        chk("stall_one_kv", kv_count, 1);
        tick();
        chk("stall_hold", ostar_fb, vec3(q(1), q(2), q(1)));
        join_v(vec3(q(250), q(-250), q(3)), vec3(q(10), q(-10), q(-1)));
        chk("sat_pos", ostar_fb[0], 26'h1FFFFFF);
        chk("sat_neg", ostar_fb[1], 26'h2000000);
        chk("sat_none", ostar_fb[2], q(2));
        chk("sat_kv", kv_count, 2);
        ostar_vld_in = 1;
        v_vld_in     = 1;
        #2 rst = 0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_rdy", {ostar_rdy_out, v_rdy_out}, 2'b00);
        chk("arst_fb", ostar_fb, 0);
        chk("arst_kv", kv_count, 0);
        chk("arst_ovld", o_vld_out, 0);
        ostar_vld_in = 0;
        v_vld_in     = 0;
        tick();
        rst = 1;
        tick();
        tick();
        chk("arst_idle", busy, 0);
        pulse_start();
        for (int k = 1; k <= 4; k++) join_v(ostar_fb, vec3(q(1), q(2), q(1)));
        chk("rerow_ovld", o_vld_out, 1);
        chk("rerow_oout", o_out, vec3(q(4), q(8), q(4)));
        chk("rerow_kv", kv_count, 3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
